truth_table_sweeper: RTL and testbench

- Controller that sequences a 2-input combinational unit under test (inputs a, b; output out) through all four input rows.
- Holds each row for a settle window, samples out, and compares it against a parameterised expected truth table with a care mask.
- Sits beside a combinational evaluation block as its stimulus driver and checker; reports a one-shot pass/fail summary plus per-row detail.

---
 rtl/truth_table_sweeper.sv | 105 ++++++++++
 tb/tb_truth_table_sweeper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Stimulus driver and checker for a 2-input combinational unit.
// Walks rows 00..11, samples after a settle window, flags mismatches.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXPECT = 4'b0001,
    parameter logic [3:0]  CARE   = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [3:0] obs
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       miss;

    assign miss = CARE[idx] & (dut_out ^ EXPECT[idx]);
    assign busy = (state == WAIT) || (state == SAMPLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 8'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            obs       <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        fail_mask      <= 4'd0;
                        obs            <= 4'd0;
                        pass           <= 1'b0;
                        idx            <= 2'd0;
                        cnt            <= 8'd0;
                        {dut_a, dut_b} <= 2'b00;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        {dut_a, dut_b} <= 2'b00;
                        pass           <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == LAST) begin
                            state <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        {dut_a, dut_b} <= 2'b00;
                        pass           <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        obs[idx] <= dut_out;
                        if (miss) begin
                            fail_mask[idx] <= 1'b1;
                        end
                        if (idx == 2'd3) begin
                            // pass must already be valid while done is high
                            pass  <= ~|{fail_mask, miss};
                            state <= DONE;
                        end else begin
                            idx            <= idx + 2'd1;
                            {dut_a, dut_b} <= idx + 2'd1;
                            cnt            <= 8'd0;
                            state          <= WAIT;
                        end
                    end
                end
                DONE: begin
                    {dut_a, dut_b} <= 2'b00;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three configurations, a row-level
// reference model compared every cycle, plus literal checkpoints.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;

    logic [2:0] pa, pb, uo, busy_v, done_v, pass_v;
    logic [2:0] held = 3'b000;
    logic [3:0] fm_v [3];
    logic [3:0] obs_v [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;

    int         per [3] = '{3, 3, 2};
    logic [3:0] mexp [3] = '{4'b0001, 4'b1001, 4'b0001};
    logic [3:0] mcare [3] = '{4'b0111, 4'b1111, 4'b0111};

    logic       act [3] = '{1'b0, 1'b0, 1'b0};
    int         t0 [3] = '{0, 0, 0};
    logic [3:0] m_obs [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] m_fm [3] = '{4'd0, 4'd0, 4'd0};
    logic       m_pass [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    truth_table_sweeper u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(pa[0]), .dut_b(pb[0]), .dut_out(uo[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .fail_mask(fm_v[0]), .obs(obs_v[0])
    );

    truth_table_sweeper #(.SETTLE(2), .EXPECT(4'b1001), .CARE(4'b1111)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(pa[1]), .dut_b(pb[1]), .dut_out(uo[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .fail_mask(fm_v[1]), .obs(obs_v[1])
    );

    truth_table_sweeper #(.SETTLE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(pa[2]), .dut_b(pb[2]), .dut_out(uo[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .fail_mask(fm_v[2]), .obs(obs_v[2])
    );

    // Units under test: 0 = xnor, 1 = stuck at 0, 2 = xnor that latches on row 11
    always_comb begin
        uo = 3'b000;
        for (int i = 0; i < 3; i++) begin
            case (mode)
                2'd0: uo[i] = pa[i] ~^ pb[i];
                2'd1: uo[i] = 1'b0;
                default: uo[i] = (pa[i] & pb[i]) ? held[i] : (pa[i] ~^ pb[i]);
            endcase
        end
    end

    always @(posedge clk) held <= uo;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: a sweep is a start cycle plus 4 rows of per[i] cycles
    always @(posedge clk or negedge rst_n) begin
        int k;
        int r;
        logic [3:0] nf;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                act[i] <= 1'b0;
                t0[i] <= 0;
                m_obs[i] <= 4'd0;
                m_fm[i] <= 4'd0;
                m_pass[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!act[i]) begin
                    if (start) begin
                        act[i] <= 1'b1;
                        t0[i] <= cyc + 1;
                        m_obs[i] <= 4'd0;
                        m_fm[i] <= 4'd0;
                        m_pass[i] <= 1'b0;
                    end
                end else begin
                    k = cyc - t0[i];
                    if (k == 4 * per[i]) begin
                        act[i] <= 1'b0;
                    end else if (abort) begin
                        act[i] <= 1'b0;
                        m_pass[i] <= 1'b0;
                    end else if (k % per[i] == per[i] - 1) begin
                        r = k / per[i];
                        nf = m_fm[i];
                        if (mcare[i][r] && (uo[i] != mexp[i][r])) nf[r] = 1'b1;
                        m_obs[i][r] <= uo[i];
                        m_fm[i] <= nf;
                        if (r == 3) m_pass[i] <= (nf == 4'd0);
                    end
                end
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        int k;
        logic eb, ed;
        logic [1:0] er;
        for (int i = 0; i < 3; i++) begin
            eb = 1'b0;
            ed = 1'b0;
            er = 2'd0;
            if (act[i]) begin
                k = cyc - t0[i];
                if (k < 4 * per[i]) begin
                    eb = 1'b1;
                    er = 2'(k / per[i]);
                end else begin
                    ed = 1'b1;
                    er = 2'd3;
                end
            end
            chk($sformatf("u%0d pins c%0d", i, cyc), 8'({pa[i], pb[i]}), 8'(er));
            chk($sformatf("u%0d busy c%0d", i, cyc), 8'(busy_v[i]), 8'(eb));
            chk($sformatf("u%0d done c%0d", i, cyc), 8'(done_v[i]), 8'(ed));
            chk($sformatf("u%0d pass c%0d", i, cyc), 8'(pass_v[i]), 8'(m_pass[i]));
            chk($sformatf("u%0d fail_mask c%0d", i, cyc), 8'(fm_v[i]), 8'(m_fm[i]));
            chk($sformatf("u%0d obs c%0d", i, cyc), 8'(obs_v[i]), 8'(m_obs[i]));
        end
    end

    task automatic at(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        base = cyc;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", 8'(busy_v), 8'd0);
        chk("reset pass", 8'(pass_v), 8'd0);
        chk("reset obs", 8'(obs_v[0]), 8'd0);
        rst_n = 1'b1;

        // correct unit, stray starts, then start held high
        mode = 2'd0;
        kick();
        at(1);
        start = 1'b0;
        chk("t1 pins c1", 8'({pa[0], pb[0]}), 8'd0);
        chk("t1 busy c1", 8'(busy_v[0]), 8'd1);
        at(3);
        start = 1'b1;
        at(4);
        start = 1'b0;
        chk("t1 pins c4", 8'({pa[0], pb[0]}), 8'd1);
        at(7);
        chk("t1 pins c7", 8'({pa[0], pb[0]}), 8'd2);
        at(9);
        chk("t1 u2 done c9", 8'(done_v[2]), 8'd1);
        at(10);
        chk("t1 pins c10", 8'({pa[0], pb[0]}), 8'd3);
        at(12);
        chk("t1 done c12", 8'(done_v[0]), 8'd0);
        at(13);
        chk("t1 done c13", 8'(done_v[0]), 8'd1);
        chk("t1 pass c13", 8'(pass_v[0]), 8'd1);
        start = 1'b1;
        at(14);
        chk("t1 done c14", 8'(done_v[0]), 8'd0);
        chk("t1 obs", 8'(obs_v[0]), 8'b1001);
        chk("t1 fail_mask", 8'(fm_v[0]), 8'd0);
        chk("t1 u1 pass", 8'(pass_v[1]), 8'd1);
        at(15);
        chk("t1 busy c15", 8'(busy_v[0]), 8'd1);
        chk("t1 pins c15", 8'({pa[0], pb[0]}), 8'd0);
        at(26);
        chk("t1 done c26", 8'(done_v[0]), 8'd0);
        at(27);
        chk("t1 done c27", 8'(done_v[0]), 8'd1);
        start = 1'b0;
        at(45);

        // stuck-at-0 unit
        mode = 2'd1;
        kick();
        at(1);
        start = 1'b0;
        at(13);
        chk("t2 done c13", 8'(done_v[0]), 8'd1);
        at(14);
        chk("t2 pass", 8'(pass_v[0]), 8'd0);
        chk("t2 fail_mask", 8'(fm_v[0]), 8'b0001);
        chk("t2 obs", 8'(obs_v[0]), 8'b0000);
        at(30);

        // latching unit: don't-care vs full care
        mode = 2'd2;
        kick();
        at(1);
        start = 1'b0;
        at(14);
        chk("t3 obs", 8'(obs_v[0]), 8'b0001);
        chk("t3 fail_mask", 8'(fm_v[0]), 8'b0000);
        chk("t3 pass", 8'(pass_v[0]), 8'd1);
        chk("t3 u1 fail_mask", 8'(fm_v[1]), 8'b1000);
        chk("t3 u1 pass", 8'(pass_v[1]), 8'd0);
        at(30);

        // abort mid-sweep
        mode = 2'd0;
        kick();
        at(1);
        start = 1'b0;
        at(5);
        abort = 1'b1;
        at(6);
        abort = 1'b0;
        chk("t4 busy c6", 8'(busy_v[0]), 8'd0);
        chk("t4 pins c6", 8'({pa[0], pb[0]}), 8'd0);
        chk("t4 pass c6", 8'(pass_v[0]), 8'd0);
        chk("t4 obs0 c6", 8'(obs_v[0][0]), 8'd1);
        at(13);
        chk("t4 done c13", 8'(done_v[0]), 8'd0);
        at(20);

        // asynchronous reset mid-sweep
        kick();
        at(1);
        start = 1'b0;
        at(7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 pins", 8'({pa[0], pb[0]}), 8'd0);
        chk("t5 busy", 8'(busy_v[0]), 8'd0);
        chk("t5 done", 8'(done_v[0]), 8'd0);
        chk("t5 fail_mask", 8'(fm_v[0]), 8'd0);
        chk("t5 obs", 8'(obs_v[0]), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
